// File: rtl/grayscale_wr_buffer_if.sv
// grayscale_wr_buffer_if: producer/consumer bundle between the grayscale datapath, the write buffer and the c1 write engine.
interface grayscale_wr_buffer_if #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 64
);
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   valid_in;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   valid_out;
  logic                   ready_in;
  logic                   almost_full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  modport master (
    output data_in, valid_in, ready_in,
    input  data_out, valid_out, almost_full, count, overflow
  );
  modport slave (
    input  data_in, valid_in, ready_in,
    output data_out, valid_out, almost_full, count, overflow
  );
endinterface

// File: rtl/grayscale_wr_buffer.sv
// grayscale_wr_buffer: elastic FWFT FIFO from grayscale output to the CCI-P c1 write path with almost_full read throttle.
// Define GRAYSCALE_WRBUF_STATS_EN to add the hwm / stall_cycles statistics outputs.
module grayscale_wr_buffer #(
  parameter int DATA_WIDTH    = 512,
  parameter int DEPTH         = 64,
  parameter int ALMFULL_SLACK = 16
) (
  input logic                   clk,
  input logic                   reset,
  grayscale_wr_buffer_if.slave  bus
`ifdef GRAYSCALE_WRBUF_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] hwm,
  output logic [31:0]            stall_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] next_count;
  logic pop, push, load, mem_any, bypass;
  // count includes the head register, so the array holds count - valid_out lines
  always_comb begin
    pop        = bus.valid_out && bus.ready_in;
    push       = bus.valid_in && (bus.count < CW'(DEPTH) || pop);
    load       = !bus.valid_out || pop;
    mem_any    = bus.count != CW'(bus.valid_out);
    bypass     = push && load && !mem_any;
    next_count = bus.count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk)
    if (push && !bypass) mem[wr_ptr] <= bus.data_in;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.count       <= '0;
      bus.valid_out   <= 1'b0;
      bus.data_out    <= '0;
      bus.almost_full <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.count       <= next_count;
      bus.almost_full <= next_count >= CW'(DEPTH - ALMFULL_SLACK);
      bus.overflow    <= bus.overflow || (bus.valid_in && !push);
      if (push && !bypass) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        bus.valid_out <= mem_any || push;
        if (mem_any) begin
          bus.data_out <= mem[rd_ptr];
          rd_ptr       <= rd_ptr + AW'(1);
        end else if (push) begin
          bus.data_out <= bus.data_in;
        end
      end
    end
  end
`ifdef GRAYSCALE_WRBUF_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm          <= '0;
      stall_cycles <= '0;
    end else begin
      hwm          <= bus.count > hwm ? bus.count : hwm;
      stall_cycles <= (bus.valid_out && !bus.ready_in && stall_cycles != '1) ? stall_cycles + 32'd1 : stall_cycles;
    end
  end
`endif
endmodule

// File: tb/tb_grayscale_wr_buffer.sv
// tb_grayscale_wr_buffer: randomized self-checking bench against a queue-based occupancy model.
// Honours GRAYSCALE_WRBUF_STATS_EN to also check hwm and stall_cycles.
module tb_grayscale_wr_buffer;
  localparam int DW    = 512;
  localparam int DEPTH = 64;
  localparam int SLACK = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  grayscale_wr_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
`ifdef GRAYSCALE_WRBUF_STATS_EN
  logic [$clog2(DEPTH):0] hwm;
  logic [31:0] stall_cycles;
  grayscale_wr_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)) dut (
    .clk(clk), .reset(reset), .bus(bus), .hwm(hwm), .stall_cycles(stall_cycles));
`else
  grayscale_wr_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMFULL_SLACK(SLACK)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif
  logic [DW-1:0] q[$];
  bit ovf_m;
  int hwm_m;
  int unsigned stall_m;
  int vecs = 0;
  int errs = 0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] l;
    for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction
  task automatic check_all();
    chk("valid_out", bus.valid_out, q.size() > 0);
    chk("count", bus.count, q.size());
    chk("almost_full", bus.almost_full, q.size() >= DEPTH - SLACK);
    chk("overflow", bus.overflow, ovf_m);
    if (q.size() > 0) chk("data_out", bus.data_out, q[0]);
`ifdef GRAYSCALE_WRBUF_STATS_EN
    chk("hwm", hwm, hwm_m);
    chk("stall_cycles", stall_cycles, stall_m);
`endif
  endtask
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    bit pop, acc;
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.ready_in = r;
    pop = q.size() > 0 && r;
    acc = v && (q.size() < DEPTH || pop);
    if (q.size() > hwm_m) hwm_m = q.size();
    if (q.size() > 0 && !r && stall_m != 32'hFFFF_FFFF) stall_m++;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    if (v && !acc) ovf_m = 1'b1;
    check_all();
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    #1;
    q.delete();
    ovf_m = 1'b0;
    hwm_m = 0;
    stall_m = 0;
    check_all();
    chk("reset_data_out", bus.data_out, '0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.data_in  = '0;
    do_reset();
    step(1'b1, DW'(512'hA5), 1'b1);
    chk("single_head", bus.data_out, DW'(512'hA5));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 200; i++) step(1'b1, rnd_line(), 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 48; i++) step(1'b1, rnd_line(), 1'b0);
    chk("throttle_af", bus.almost_full, 1'b1);
    while (q.size() > 0) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 65; i++) step(1'b1, rnd_line(), 1'b0);
    chk("full_overflow", bus.overflow, 1'b1);
    for (int i = 0; i < 70; i++) step(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd_line(), 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, rnd_line(), 1'b1);
    chk("wrap_no_overflow", bus.overflow, 1'b0);
    while (q.size() > 0) step(1'b0, '0, $urandom_range(0, 1));
    for (int ph = 0; ph < 8; ph++) begin
      int pv, pr;
      pv = $urandom_range(30, 100);
      pr = $urandom_range(10, 100);
      for (int i = 0; i < 250; i++)
        step($urandom_range(0, 99) < pv, rnd_line(), $urandom_range(0, 99) < pr);
    end
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, rnd_line(), 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1), rnd_line(), $urandom_range(0, 1));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/grayscale_wr_buffer.md
Name: grayscale_wr_buffer

Overview:
- Elastic FIFO between the grayscale datapath output (data_rx/valid_rx) and the requestor's CCI-P c1 write path.
- The grayscale pipeline has no backpressure, so this block absorbs result lines while the write channel is throttled by c1TxAlmFull.
- It returns an almost_full credit signal so the requestor stops issuing c0 reads early enough that in-flight lines never overflow.

Parameters:
- DATA_WIDTH, 512, width of one cache line of pixel data.
- DEPTH, 64, FIFO entries; power of two, at least 4.
- ALMFULL_SLACK, 16, almost_full asserts when count >= DEPTH-ALMFULL_SLACK; covers read round-trip plus grayscale pipeline latency.

Ports:
- clk  in  1  pClk domain clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DATA_WIDTH  result line from grayscale.
- valid_in  in  1  push strobe; no backpressure toward the producer.
- data_out  out  DATA_WIDTH  head line for the write engine.
- valid_out  out  1  head is valid.
- ready_in  in  1  write engine consumes the head this cycle; requestor drives this as !c1TxAlmFull and write-state ready.
- almost_full  out  1  registered throttle for read issue.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky error flag: a push was dropped.

Behaviour:
- Reset (async assert, synchronous release on clk):
  - Read/write pointers = 0, count = 0.
  - valid_out = 0, data_out = 0, almost_full = 0, overflow = 0.
  - Reset mid-operation discards all stored lines with no drain.
- Storage: DEPTH-entry array with a registered head stage in first-word-fall-through style. A push into an empty FIFO gives valid_out=1 with that data on the next cycle (1-cycle latency).
- Pop: occurs when valid_out && ready_in. The next entry appears at the head on the following cycle.
  - Sustained push+pop runs at 1 line/clk, with no bubbles once non-empty.
  - Consecutive pops with no bubbles are allowed.
- Push acceptance: accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the line is dropped: overflow is set to 1 and stays set until reset, and count and pointers are unchanged.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop or on neither.
  - Never below 0: pop requires valid_out.
- Pointers: each is $clog2(DEPTH) bits and wraps from DEPTH-1 to 0 without any special handling.
- almost_full:
  - Registered from the next-state count: 1 when next_count >= DEPTH-ALMFULL_SLACK, else 0.
  - It therefore changes the same cycle count changes.
- ready_in is ignored when valid_out=0.
- data_out is held stable while valid_out=1 and ready_in=0.
- A simultaneous push and pop when empty is impossible, because valid_out=0. In that case the push is accepted and count goes 0 to 1.
- No combinational path from ready_in to almost_full. data_out and valid_out are registered.

Optional Feature:
- Macro: GRAYSCALE_WRBUF_STATS_EN.
- When defined, the block adds:
  - Output hwm [$clog2(DEPTH):0]: the occupancy high-water mark, updated each cycle to max(hwm, count).
  - Output stall_cycles [31:0]: counts cycles with valid_out=1 && ready_in=0, saturating at 32'hFFFF_FFFF.
  - Both clear on reset; the CSR block exposes them via MMIO reads.
- When undefined, these ports and their registers do not exist, and functional behaviour is otherwise identical.

Test Plan:
- Single line: after reset, push 512'hA5 (ready_in=1) -> valid_out=1 with data 512'hA5 exactly 1 cycle later; popped next cycle; count returns to 0; overflow=0.
- Stream: 200 consecutive pushes, ready_in=1 -> 200 lines out, in order, no gaps after the first; count stays at most 1; almost_full stays 0.
- Throttle (DEPTH=64, SLACK=16): ready_in=0, push 48 lines -> almost_full rises in the cycle count becomes 48; at 47 it is 0. Release ready_in -> almost_full falls when count drops to 47.
- Full/overflow: ready_in=0, push 65 lines -> count=64 and overflow=1. Then drain -> exactly lines 1..64 in order, and overflow stays 1.
- Full with simultaneous pop: count=64, push and pop in the same cycle -> push accepted, count stays 64, overflow=0. Pointers wrap and the sequence stays intact over 3×DEPTH lines.
- Reset mid-stream: count=30, assert reset for 1 cycle -> valid_out, count and almost_full are 0 immediately (async). With GRAYSCALE_WRBUF_STATS_EN, hwm=0 and stall_cycles=0.
